// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared constants and types for the CPU front end.
//   CPU_A_W      : default ROM address / PC width
//   CPU_D_W      : default instruction word width
//   CPU_RESET_PC : PC value loaded on reset
//   fetch_entry_t: one instruction-buffer entry {pc, word}
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int CPU_A_W      = 4;
    localparam int CPU_D_W      = 18;
    localparam int CPU_RESET_PC = 0;

    typedef struct packed {
        logic [CPU_A_W-1:0] pc;
        logic [CPU_D_W-1:0] word;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO holding fetched instructions. The head entry is
// readable combinationally so that a push becomes visible one cycle later.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_push       : write i_wr_data at the tail
//   i_pop        : drop the head entry
//   i_flush      : empty the FIFO (overrides push/pop)
//   i_wr_data    : entry to push
//   o_rd_data    : head entry, zero when empty
//   o_count      : number of valid entries (0..DEPTH)
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int W     = 22,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [W-1:0]             i_wr_data,
    output logic [W-1:0]             o_rd_data,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    // Ignore illegal requests; a push into a full FIFO is fine if the head leaves.
    assign w_do_pop  = i_pop & ~w_empty;
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count   = r_count;

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Fetch stage in front of the program ROM. Owns the PC, reads the ROM with
// zero-latency combinational data, and buffers {pc, word} entries for decode
// behind a valid/ready handshake. A redirect flushes the buffer and reloads PC.
// Optional feature macro: INSTR_FETCH_PERF_EN adds stall_cnt, a saturating
// count of cycles where fetch was wanted but the buffer blocked it.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   fetch_en            : allow new ROM reads
//   rom_addr/rom_data   : ROM address (= PC) and combinational read data
//   rom_cs/rom_oe       : ROM strobes, high in issue cycles
//   rom_we              : tied low
//   redirect_valid/_pc  : branch redirect request and target
//   instr_valid/_ready  : handshake towards decode
//   instr_data/instr_pc : head instruction word and its address (0 if empty)
//   stall_cnt           : (INSTR_FETCH_PERF_EN only) backpressure cycle count
// -----------------------------------------------------------------------------
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int A_W      = CPU_A_W,
    parameter int D_W      = CPU_D_W,
    parameter int DEPTH    = 2,
    parameter int RESET_PC = CPU_RESET_PC
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           fetch_en,
    output logic [A_W-1:0] rom_addr,
    input  logic [D_W-1:0] rom_data,
    output logic           rom_cs,
    output logic           rom_oe,
    output logic           rom_we,
    input  logic           redirect_valid,
    input  logic [A_W-1:0] redirect_pc,
    output logic           instr_valid,
    input  logic           instr_ready,
    output logic [D_W-1:0] instr_data,
`ifdef INSTR_FETCH_PERF_EN
    output logic [15:0]    stall_cnt,
`endif
    output logic [A_W-1:0] instr_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [A_W-1:0]     r_pc;
    logic [CW-1:0]      w_count;
    logic [A_W+D_W-1:0] w_head;
    logic               w_full;
    logic               w_pop;
    logic               w_issue;

    assign w_full      = (w_count == CW'(DEPTH));
    assign instr_valid = (w_count != '0);
    assign w_pop       = instr_valid & instr_ready;
    // rst_n gates the strobes so they fall the instant reset asserts.
    assign w_issue     = rst_n & fetch_en & ~redirect_valid & (~w_full | w_pop);

    assign rom_addr = r_pc;
    assign rom_cs   = w_issue;
    assign rom_oe   = w_issue;
    assign rom_we   = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= A_W'(RESET_PC);
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
        end else if (w_issue) begin
            r_pc <= r_pc + 1'b1;
        end
    end

    fetch_fifo #(
        .W     (A_W + D_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_issue),
        .i_pop     (w_pop),
        .i_flush   (redirect_valid),
        .i_wr_data ({r_pc, rom_data}),
        .o_rd_data (w_head),
        .o_count   (w_count)
    );

    // The FIFO already returns zero when empty.
    assign instr_pc   = w_head[A_W+D_W-1:D_W];
    assign instr_data = w_head[D_W-1:0];

`ifdef INSTR_FETCH_PERF_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (fetch_en && !redirect_valid && !w_issue && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
    import cpu_pkg::*;

    localparam int A_W   = 4;
    localparam int D_W   = 18;
    localparam int DEPTH = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           fetch_en = 1'b0;
    logic           instr_ready = 1'b0;
    logic           redirect_valid = 1'b0;
    logic [A_W-1:0] redirect_pc = '0;
    logic [A_W-1:0] rom_addr;
    logic [D_W-1:0] rom_data;
    logic           rom_cs, rom_oe, rom_we;
    logic           instr_valid;
    logic [D_W-1:0] instr_data;
    logic [A_W-1:0] instr_pc;
`ifdef INSTR_FETCH_PERF_EN
    logic [15:0]    stall_cnt;
`endif

    logic [D_W-1:0] rom_mem [16];
    assign rom_data = rom_mem[rom_addr];

    always #5 clk = ~clk;

    instr_fetch #(.A_W(A_W), .D_W(D_W), .DEPTH(DEPTH), .RESET_PC(0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .rom_cs         (rom_cs),
        .rom_oe         (rom_oe),
        .rom_we         (rom_we),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
`ifdef INSTR_FETCH_PERF_EN
        .stall_cnt      (stall_cnt),
`endif
        .instr_pc       (instr_pc)
    );

    int n_cmp = 0;
    int n_bad = 0;

    fetch_entry_t   exp_q[$];
    logic [A_W-1:0] m_pc;

    typedef struct {
        logic       fe, rdy, rv;
        logic [3:0] rpc;
        logic       e_valid;
        logic [3:0] e_pc;
        logic       e_cs;
        logic [3:0] e_addr;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic fe, input logic rdy, input logic rv,
                                input logic [3:0] rpc, input logic ev,
                                input logic [3:0] epc, input logic ecs,
                                input logic [3:0] eaddr);
        vec_t v;
        v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.e_valid = ev; v.e_pc = epc; v.e_cs = ecs; v.e_addr = eaddr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fe, input logic rdy, input logic rv, input logic [3:0] rpc);
        @(negedge clk);
        fetch_en       = fe;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    // Scoreboard: compare against the model, advance it, then take the edge.
    task automatic sb_cycle();
        fetch_entry_t head;
        logic e_v, pop, issue;
        e_v   = (exp_q.size() != 0);
        head  = e_v ? exp_q[0] : '0;
        pop   = e_v & instr_ready;
        issue = fetch_en & ~redirect_valid & ((exp_q.size() < DEPTH) | pop);
        chk("sb_valid", 32'(instr_valid), 32'(e_v));
        chk("sb_data",  32'(instr_data),  32'(head.word));
        chk("sb_pc",    32'(instr_pc),    32'(head.pc));
        chk("sb_cs",    32'(rom_cs),      32'(issue));
        chk("sb_oe",    32'(rom_oe),      32'(issue));
        chk("sb_we",    32'(rom_we),      32'(0));
        chk("sb_addr",  32'(rom_addr),    32'(m_pc));
        if (pop) begin
            $display("pop pc=%0d word=%05h", head.pc, head.word);
            void'(exp_q.pop_front());
        end
        if (redirect_valid) begin
            exp_q.delete();
            m_pc = redirect_pc;
        end else if (issue) begin
            exp_q.push_back('{pc: m_pc, word: rom_mem[m_pc]});
            m_pc = m_pc + 1'b1;
        end
        @(posedge clk);
    endtask

    task automatic step(input logic fe, input logic rdy, input logic rv, input logic [3:0] rpc);
        drive(fe, rdy, rv, rpc);
        sb_cycle();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(instr_valid), 32'(0));
        chk({tag, "_data"},  32'(instr_data),  32'(0));
        chk({tag, "_ipc"},   32'(instr_pc),    32'(0));
        chk({tag, "_cs"},    32'(rom_cs),      32'(0));
        chk({tag, "_oe"},    32'(rom_oe),      32'(0));
        chk({tag, "_we"},    32'(rom_we),      32'(0));
        chk({tag, "_addr"},  32'(rom_addr),    32'(0));
`ifdef INSTR_FETCH_PERF_EN
        chk({tag, "_stall"}, 32'(stall_cnt),   32'(0));
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            rom_mem[i] = 18'(i * 18'h01357) ^ 18'h2a000;
        end
        rom_mem[0] = 18'h0af45;
        rom_mem[1] = 18'h0aa31;

        vecs[0]  = mk(1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 4'd0,  1'b1, 4'd0);
        vecs[1]  = mk(1'b1, 1'b1, 1'b0, 4'd0,  1'b1, 4'd0,  1'b1, 4'd1);
        vecs[2]  = mk(1'b0, 1'b1, 1'b0, 4'd0,  1'b1, 4'd1,  1'b0, 4'd2);
        vecs[3]  = mk(1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0,  1'b1, 4'd2);
        vecs[4]  = mk(1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 4'd2,  1'b1, 4'd3);
        vecs[5]  = mk(1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 4'd2,  1'b0, 4'd4);
        vecs[6]  = mk(1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 4'd2,  1'b0, 4'd4);
        vecs[7]  = mk(1'b1, 1'b1, 1'b0, 4'd0,  1'b1, 4'd2,  1'b1, 4'd4);
        vecs[8]  = mk(1'b1, 1'b1, 1'b0, 4'd0,  1'b1, 4'd3,  1'b1, 4'd5);
        vecs[9]  = mk(1'b1, 1'b1, 1'b1, 4'd9,  1'b1, 4'd4,  1'b0, 4'd6);
        vecs[10] = mk(1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 4'd0,  1'b1, 4'd9);
        vecs[11] = mk(1'b1, 1'b1, 1'b0, 4'd0,  1'b1, 4'd9,  1'b1, 4'd10);
        vecs[12] = mk(1'b1, 1'b1, 1'b1, 4'd14, 1'b1, 4'd10, 1'b0, 4'd11);
        vecs[13] = mk(1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 4'd0,  1'b1, 4'd14);
        vecs[14] = mk(1'b1, 1'b1, 1'b0, 4'd0,  1'b1, 4'd14, 1'b1, 4'd15);
        vecs[15] = mk(1'b1, 1'b1, 1'b0, 4'd0,  1'b1, 4'd15, 1'b1, 4'd0);
        vecs[16] = mk(1'b1, 1'b1, 1'b0, 4'd0,  1'b1, 4'd0,  1'b1, 4'd1);
        vecs[17] = mk(1'b1, 1'b1, 1'b0, 4'd0,  1'b1, 4'd1,  1'b1, 4'd2);

        // Power-on reset with fetch requested: strobes must stay low.
        fetch_en    = 1'b1;
        instr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_reset_outputs("por");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        m_pc  = '0;
        exp_q.delete();

        // Table-driven run: startup, backpressure, redirect, PC wrap.
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].fe, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
            chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_ipc", i),   32'(instr_pc),    32'(vecs[i].e_pc));
            chk($sformatf("v%0d_cs", i),    32'(rom_cs),      32'(vecs[i].e_cs));
            chk($sformatf("v%0d_addr", i),  32'(rom_addr),    32'(vecs[i].e_addr));
            sb_cycle();
        end

        // Asynchronous reset between edges while entries are in flight.
        @(negedge clk);
        fetch_en    = 1'b1;
        instr_ready = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        exp_q.delete();
        m_pc = '0;
        @(posedge clk);
        #1;
        chk_reset_outputs("mid_rst_hold");
        #1;
        rst_n = 1'b1;

        // Fill the buffer, then hold ready low for 10 backpressure cycles.
        step(1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0, 4'd0);
        end
`ifdef INSTR_FETCH_PERF_EN
        @(negedge clk);
        #1;
        chk("stall_cnt_10", 32'(stall_cnt), 32'(10));
`endif

        // Drain and keep streaming.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b0, 4'd0);
        end
        step(1'b0, 1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b1, 1'b0, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the program ROM.
- Drives the ROM address, chip-select and output-enable, captures the 18-bit instruction word, and buffers it in a small FIFO for the decode stage using a valid/ready handshake.
- Owns the program counter; decode or execute can redirect it on branches.

Parameters:
A_W, 4, ROM address width / PC width
D_W, 18, instruction word width
DEPTH, 2, instruction buffer entries (power of two, >=2)
RESET_PC, 0, PC value after reset

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
fetch_en  input  1  high allows new ROM reads
rom_addr  output  A_W  ROM address; always equals current PC
rom_data  input  D_W  ROM read data; combinational from rom_addr
rom_cs  output  1  ROM chip select; high in issue cycles
rom_oe  output  1  ROM output enable; high in issue cycles
rom_we  output  1  ROM write enable; constant 0
redirect_valid  input  1  branch/jump redirect request
redirect_pc  input  A_W  redirect target
instr_valid  output  1  FIFO non-empty
instr_ready  input  1  decode accepts head entry
instr_data  output  D_W  head instruction word; 0 when instr_valid=0
instr_pc  output  A_W  address of head instruction; 0 when instr_valid=0

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, count=0, rd/wr pointers=0.
- Reset outputs: instr_valid=0, instr_data=0, instr_pc=0, rom_cs=rom_oe=rom_we=0, rom_addr=RESET_PC.
- pop = instr_valid & instr_ready.
- issue = fetch_en & ~redirect_valid & (count<DEPTH | pop).
- rom_cs = rom_oe = issue, combinational.
- On issue: rom_data is sampled at the same rising edge and {pc, rom_data} is pushed. pc <= pc+1 modulo 2^A_W, so 2^A_W-1 wraps to 0. Read latency is 0 cycles from address to capture; an entry becomes visible at the head 1 cycle after issue.
- Full FIFO with simultaneous pop: issue is allowed, push and pop both occur, count unchanged.
- Empty FIFO: no pop possible; instr_data/instr_pc held at 0.
- Redirect (has priority over everything):
  - If pop occurs in the same cycle, the popped entry counts as consumed by decode.
  - The FIFO is then flushed (count=0, pointers=0) and pc <= redirect_pc.
  - No issue that cycle.
  - First fetch from redirect_pc can occur in the next cycle, giving instr_valid 2 cycles after redirect at earliest.
- fetch_en low: no issue; pc holds; FIFO continues draining.
- Reset asserted mid-operation clears all state immediately, with no partial pushes.
- Counters: count is $clog2(DEPTH)+1 bits. Pointers are $clog2(DEPTH) bits and wrap naturally.

Optional Feature:
- Macro: INSTR_FETCH_PERF_EN.
- When defined:
  - Adds output stall_cnt [15:0].
  - Increments (saturating at 16'hFFFF) every cycle with fetch_en=1, redirect_valid=0, and issue=0 (buffer backpressure).
  - Reset to 0.
- When undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg:
  - default A_W/D_W constants.
  - fetch entry typedef {pc[A_W], word[D_W]}.
  - RESET_PC constant.
- Sub-module fetch_fifo: synchronous FIFO with DEPTH entries.
  - Ports: push/pop/flush/data in/out, count.
  - instr_fetch instantiates it and holds only the PC, issue logic and ROM strobes.

Test Plan:
- ROM preloaded with addr0=18'h0af45, addr1=18'h0aa31; release reset with fetch_en=1, instr_ready=1 -> cycle 1 after release: instr_valid=1, instr_data=18'h0af45, instr_pc=0; next cycle 18'h0aa31, instr_pc=1; rom_we never 1.
- instr_ready=0, fetch_en=1 -> exactly DEPTH(2) issues, then rom_cs=0 and pc=2 held; raise ready -> entries 0,1 delivered in order, then fetch resumes at 2 without a gap.
- Redirect to 4'd9 while FIFO holds 2 entries and ready=1 -> head popped that cycle, FIFO empty next cycle, rom_addr=9 with rom_cs=1, instr_pc=9 valid the following cycle.
- Run from pc=14 with ready=1 -> instr_pc sequence 14, 15, 0, 1.
- Assert rst_n low mid-stream (asynchronously, between edges) -> instr_valid, rom_cs, rom_oe drop immediately; rom_addr=RESET_PC; no entry appears until after release.
- With INSTR_FETCH_PERF_EN and ready=0 for 10 cycles after the FIFO fills -> stall_cnt=10.
